// File: rtl/rand_seq_arbiter_pkg.sv
// Shared types and constants for the random-sequence arbiter slice.
// Covers the FSM state encoding, the widths and a one-hot to index helper.
package rand_seq_pkg;

  localparam int SEQ_W   = 288;
  localparam int TIMER_W = 8;
  // Requester index width; NUM_REQ never exceeds 8.
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESEED  = 2'd1,
    GEN     = 2'd2,
    DELIVER = 2'd3
  } state_t;

  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [7:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rand_seq_arbiter_if.sv
// Requester and generator signals of the arbiter, grouped into a single bundle.
// The arbiter uses the slave view, and the cores/generator use the master view.
interface rand_seq_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SEQ_W   = rand_seq_pkg::SEQ_W
);
    // Handshake: req[i] stays high until requester i sees seq_valid[i] and returns ack[i].
    // seq_data stays stable while seq_valid is high, and it clears on the cycle after ack.
    // The generator is reseeded by a one-cycle gen_reset and runs while gen_enable is high.
    // gen_seq is meaningful only while gen_done is high.
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] seq_valid;
    logic [SEQ_W-1:0]   seq_data;
    logic               gen_reset;
    logic               gen_enable;
    logic               gen_done;
    logic [SEQ_W-1:0]   gen_seq;

    modport master (
        output req, ack, gen_done, gen_seq,
        input  grant, seq_valid, seq_data, gen_reset, gen_enable
    );

    modport slave (
        input  req, ack, gen_done, gen_seq,
        output grant, seq_valid, seq_data, gen_reset, gen_enable
    );
endinterface

// File: rtl/rand_seq_arbiter_rr.sv
// This is a combinational round-robin picker that returns a one-hot grant.
// It picks the first set request bit at or after ptr, and wraps around to bit 0.
module rr_arbiter
    import rand_seq_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick
);
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] pick_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   low_rot;

    // Rotate so that ptr lands on bit 0, then isolate the lowest set bit.
    // Rotate the result back by the same amount.
    assign req_dbl  = {req, req} >> ptr;
    assign req_rot  = req_dbl[NUM_REQ-1:0];
    assign low_rot  = req_rot & (-req_rot);
    assign pick_dbl = {low_rot, low_rot} << ptr;
    assign pick     = pick_dbl[2*NUM_REQ-1:NUM_REQ];
endmodule

// File: rtl/rand_seq_arbiter.sv
// This block shares one reseedable LFSR generator among NUM_REQ requesters in round-robin order.
// The flow is arbitrate, reseed, generate, then deliver the sequence to the owner.
module rand_seq_arbiter
    import rand_seq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    rand_seq_arbiter_if.slave    bus,
    output logic                 err,
    input  logic                 err_clr,
    output state_t               state_dbg
);
    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   valid_q, valid_d;
    logic [SEQ_W-1:0]     data_q, data_d;
    logic                 gen_reset_q, gen_reset_d;
    logic                 gen_enable_q, gen_enable_d;
    logic                 err_q, err_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;

    logic [NUM_REQ-1:0]   pick;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     next_ptr;
    logic                 owner_live;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req  (bus.req),
        .ptr  (ptr_q),
        .pick (pick)
    );

    assign grant_idx  = oh_to_idx(8'(grant_q));
    assign next_ptr   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign owner_live = |(bus.req & grant_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            valid_q      <= '0;
            data_q       <= '0;
            gen_reset_q  <= 1'b1;
            gen_enable_q <= 1'b0;
            err_q        <= 1'b0;
            ptr_q        <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            gen_reset_q  <= gen_reset_d;
            gen_enable_q <= gen_enable_d;
            err_q        <= err_d;
            ptr_q        <= ptr_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        valid_d      = valid_q;
        data_d       = data_q;
        gen_reset_d  = 1'b0;
        gen_enable_d = gen_enable_q;
        // Set below takes priority over a simultaneous clear.
        err_d        = err_q & ~err_clr;
        ptr_d        = ptr_q;
        timer_d      = timer_q;

        case (state_q)
            IDLE: begin
                grant_d      = '0;
                valid_d      = '0;
                data_d       = '0;
                gen_enable_d = 1'b0;
                timer_d      = '0;
                if (|bus.req) begin
                    grant_d     = pick;
                    gen_reset_d = 1'b1;
                    state_d     = RESEED;
                end
            end
            RESEED, GEN, DELIVER: begin
                // Shared release path covers abandon, timeout and completed delivery.
                if (!owner_live ||
                    (state_q == DELIVER && |(bus.ack & grant_q)) ||
                    (state_q == GEN && !bus.gen_done && timer_q == TIMER_W'(TIMEOUT))) begin
                    if (owner_live && state_q == GEN) err_d = 1'b1;
                    state_d      = IDLE;
                    grant_d      = '0;
                    valid_d      = '0;
                    data_d       = '0;
                    gen_enable_d = 1'b0;
                    timer_d      = '0;
                    ptr_d        = next_ptr;
                end else if (state_q == RESEED) begin
                    // Timer counts GEN cycles including the current one.
                    gen_enable_d = 1'b1;
                    timer_d      = TIMER_W'(1);
                    state_d      = GEN;
                end else if (state_q == GEN) begin
                    if (bus.gen_done) begin
                        data_d       = bus.gen_seq;
                        valid_d      = grant_q;
                        gen_enable_d = 1'b0;
                        state_d      = DELIVER;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant      = grant_q;
    assign bus.seq_valid  = valid_q;
    assign bus.seq_data   = data_q;
    assign bus.gen_reset  = gen_reset_q;
    assign bus.gen_enable = gen_enable_q;
    assign err            = err_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_rand_seq_arbiter.sv
// This is the bench for rand_seq_arbiter, with a step-counting generator model and a round-robin reference model.
// It drives directed scenarios and random transactions, and the scoreboard checks each delivered sequence.
module tb_rand_seq_arbiter;
  import rand_seq_pkg::*;

  localparam int N  = 4;
  localparam int TO = 255;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   err;
  logic   err_clr = 1'b0;
  state_t state_dbg;

  rand_seq_arbiter_if #(.NUM_REQ(N)) bus();

  rand_seq_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err       (err),
    .err_clr   (err_clr),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // generator model: done once it has been enabled for gen_steps cycles since reseed
  int unsigned      gen_cnt;
  int unsigned      gen_steps = 32'hFFFF_FFFF;
  logic [SEQ_W-1:0] cur_seq = '0;

  always @(posedge clk or posedge reset) begin
    if (reset)               gen_cnt <= 0;
    else if (bus.gen_reset)  gen_cnt <= 0;
    else if (bus.gen_enable) gen_cnt <= gen_cnt + 1;
  end
  assign bus.gen_done = (gen_cnt >= gen_steps);
  assign bus.gen_seq  = bus.gen_done ? cur_seq : '0;

  // scoreboard
  logic [SEQ_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int model_ptr = 0;

  task automatic check_val(input string tag, input logic [SEQ_W-1:0] act, input logic [SEQ_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic new_seq();
    for (int i = 0; i < 8; i++) cur_seq[32 + 32*i +: 32] = $urandom;
    cur_seq[31:0] = 32'h0;
  endtask

  // driver: one full request/deliver/ack transaction, starting mid-cycle in IDLE
  task automatic run_txn(input logic [N-1:0] mask, input int steps, input int ack_dly,
                         input bit wrong_ack, output logic [N-1:0] got_grant);
    int               exp_g;
    logic [N-1:0]     exp_oh;
    logic [SEQ_W-1:0] exp_d;
    bit               bad;
    exp_g  = model_pick(mask, model_ptr);
    exp_oh = '0;
    exp_oh[exp_g] = 1'b1;
    gen_steps = steps;
    new_seq();
    exp_q.push_back(cur_seq);
    bus.req = mask;
    tick();
    got_grant = bus.grant;
    check_val("grant", bus.grant, exp_oh);
    check_val("reseed_pulse", bus.gen_reset, 1'b1);
    check_val("enable_off_reseed", bus.gen_enable, 1'b0);
    tick();
    check_val("reseed_end", bus.gen_reset, 1'b0);
    check_val("enable_gen", bus.gen_enable, 1'b1);
    bad = 1'b0;
    for (int c = 3; c <= steps + 2; c++) begin
      tick();
      if (bus.seq_valid != '0 || bus.gen_reset) bad = 1'b1;
    end
    check_val("quiet_during_gen", bad, 1'b0);
    tick();
    exp_d = exp_q.pop_front();
    check_val("valid", bus.seq_valid, exp_oh);
    check_val("data", bus.seq_data, exp_d);
    check_val("enable_off_deliver", bus.gen_enable, 1'b0);
    for (int d = 0; d < ack_dly; d++) begin
      bus.ack = wrong_ack ? ~exp_oh : '0;
      tick();
      check_val("valid_hold", bus.seq_valid, exp_oh);
      check_val("data_hold", bus.seq_data, exp_d);
    end
    bus.ack = exp_oh;
    tick();
    check_val("valid_clear", bus.seq_valid, '0);
    check_val("grant_clear", bus.grant, '0);
    check_val("data_clear", bus.seq_data, '0);
    check_val("state_idle", state_dbg, IDLE);
    bus.ack = '0;
    bus.req = '0;
    model_ptr = (exp_g + 1) % N;
  endtask

  logic [N-1:0] g;
  logic [N-1:0] rr_exp[5];

  initial begin
    bus.req = '0;
    bus.ack = '0;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // reset state
    tick(); tick();
    check_val("rst_grant", bus.grant, '0);
    check_val("rst_valid", bus.seq_valid, '0);
    check_val("rst_data", bus.seq_data, '0);
    check_val("rst_gen_reset", bus.gen_reset, 1'b1);
    check_val("rst_gen_enable", bus.gen_enable, 1'b0);
    check_val("rst_err", err, 1'b0);
    reset = 1'b0;
    tick();
    check_val("post_rst_gen_reset", bus.gen_reset, 1'b0);

    // single request, 127-step generator: valid lands at cycle 130
    run_txn(4'b0001, 127, 1, 1'b0, g);
    check_val("t1_grant", g, 4'b0001);

    // requester 2 abandons mid-GEN
    gen_steps = 50;
    new_seq();
    bus.req = 4'b0100;
    tick();
    check_val("ab_grant", bus.grant, 4'b0100);
    tick(); tick(); tick();
    bus.req = '0;
    tick();
    check_val("ab_grant_clear", bus.grant, '0);
    check_val("ab_enable_off", bus.gen_enable, 1'b0);
    check_val("ab_no_valid", bus.seq_valid, '0);
    check_val("ab_idle", state_dbg, IDLE);
    model_ptr = 3;
    tick();
    run_txn(4'b1111, 4, 0, 1'b0, g);
    check_val("ab_rr_next", g, 4'b1000);

    // all requesters held: strict rotation
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, $urandom_range(1, 6), 0, 1'b0, g);
      check_val("rr_order", g, rr_exp[i]);
    end

    // generator never completes: timeout, err set wins over a same-cycle clear
    gen_steps = 32'hFFFF_FFFF;
    bus.req = 4'b0010;
    tick();
    check_val("to_grant", bus.grant, 4'b0010);
    tick();
    for (int c = 3; c <= 2 + TO - 1; c++) tick();
    check_val("to_err_before", err, 1'b0);
    check_val("to_grant_held", bus.grant, 4'b0010);
    err_clr = 1'b1;
    tick();
    check_val("to_err_set", err, 1'b1);
    check_val("to_grant_clear", bus.grant, '0);
    check_val("to_enable_off", bus.gen_enable, 1'b0);
    check_val("to_no_valid", bus.seq_valid, '0);
    bus.req = '0;
    model_ptr = 2;
    tick();
    check_val("to_err_cleared", err, 1'b0);
    err_clr = 1'b0;
    run_txn(4'b0001, 10, 1, 1'b0, g);
    check_val("to_next_req", g, 4'b0001);

    // wrong-requester ack is ignored
    run_txn(4'b0001, 3, 3, 1'b1, g);

    // random traffic
    for (int i = 0; i < 16; i++) begin
      run_txn(4'($urandom_range(1, 15)), $urandom_range(1, 12), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), g);
    end

    // async reset during DELIVER
    gen_steps = 5;
    new_seq();
    bus.req = 4'b1111;
    for (int c = 1; c <= 8; c++) tick();
    check_val("rs_in_deliver", state_dbg, DELIVER);
    #2 reset = 1'b1;
    #1;
    check_val("rs_grant", bus.grant, '0);
    check_val("rs_valid", bus.seq_valid, '0);
    check_val("rs_data", bus.seq_data, '0);
    check_val("rs_gen_reset", bus.gen_reset, 1'b1);
    check_val("rs_gen_enable", bus.gen_enable, 1'b0);
    check_val("rs_state", state_dbg, IDLE);
    bus.req = '0;
    tick();
    reset = 1'b0;
    model_ptr = 0;
    tick();
    check_val("rs_release", bus.gen_reset, 1'b0);
    run_txn(4'b1111, 2, 0, 1'b0, g);
    check_val("rs_ptr_zero", g, 4'b0001);

    check_val("exp_q_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
